qspi_tx_serializer: RTL and testbench

Drain side of the controller's 32-bit TX FIFO. The block pops words from the FIFO read port and shifts them out MSB-first on the QSPI IO lanes in single, dual or quad mode. It generates SCLK in SPI mode 0. Chip select and the command/address phases stay in the controller FSM; this block owns only the write-data phase.

---
 rtl/qspi_tx_serializer.sv | 186 ++++++++++++++++++
 tb/tb_qspi_tx_serializer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_tx_serializer.sv
// Write-data phase of the QSPI controller: pops TX FIFO words and shifts them
// out MSB-first on 1, 2 or 4 IO lanes under a mode-0 SCLK.
module qspi_tx_serializer #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16,
   parameter int DIV_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic [LEN_WIDTH-1:0]  word_count,
   input  logic [DIV_WIDTH-1:0]  clk_div,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  fifo_empty,
   output logic                  sclk,
   output logic [3:0]            io_out,
   output logic [3:0]            io_oe,
   output logic                  busy,
   output logic                  done,
   output logic                  underrun,
   output logic [2:0]            state_dbg
);

   localparam int GRP_W = $clog2(DATA_WIDTH) + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_SHIFT = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [1:0]            mode_q, mode_d;
   logic [DIV_WIDTH-1:0]  div_q, div_d;
   logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic [GRP_W-1:0]      grp_q, grp_d;
   logic [DATA_WIDTH-1:0] sh_q, sh_d, sh_next;
   logic                  sclk_q, sclk_d;
   logic                  under_q, under_d;
   logic [3:0]            io_oe_q, io_oe_d;

   function automatic logic [3:0] lead_group(input logic [1:0] m, input logic [3:0] top);
      case (m)
         2'd1:    lead_group = {2'b00, top[3:2]};
         2'd2:    lead_group = top;
         default: lead_group = {3'b000, top[3]};
      endcase
   endfunction

   function automatic logic [3:0] lane_mask(input logic [1:0] m);
      case (m)
         2'd1:    lane_mask = 4'b0011;
         2'd2:    lane_mask = 4'b1111;
         default: lane_mask = 4'b0001;
      endcase
   endfunction

   function automatic logic [GRP_W-1:0] last_group(input logic [1:0] m);
      case (m)
         2'd1:    last_group = GRP_W'(DATA_WIDTH / 2 - 1);
         2'd2:    last_group = GRP_W'(DATA_WIDTH / 4 - 1);
         default: last_group = GRP_W'(DATA_WIDTH - 1);
      endcase
   endfunction

   always_comb begin
      case (mode_q)
         2'd1:    sh_next = sh_q << 2;
         2'd2:    sh_next = sh_q << 4;
         default: sh_next = sh_q << 1;
      endcase
   end

   // fifo_rd_en is a one-cycle pop strobe, only ever raised while fifo_empty is low;
   // the popped word is taken from fifo_data exactly one cycle later, in LOAD.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      div_d      = div_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      grp_d      = grp_q;
      sh_d       = sh_q;
      sclk_d     = sclk_q;
      under_d    = under_q;
      io_oe_d    = io_oe_q;
      fifo_rd_en = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               under_d = 1'b0;
               mode_d  = mode;
               div_d   = clk_div;
               rem_d   = word_count;
               state_d = (word_count != '0) ? S_FETCH : S_DONE;
            end
         end
         S_FETCH: begin
            if (fifo_empty) begin
               under_d = 1'b1;
            end else begin
               fifo_rd_en = 1'b1;
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            sh_d    = fifo_data;
            io_oe_d = lane_mask(mode_q);
            grp_d   = last_group(mode_q);
            cnt_d   = '0;
            sclk_d  = 1'b0;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (cnt_q == div_q) begin
               cnt_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  sclk_d = 1'b0;
                  // Last group of the word: leave the lanes holding it through the fetch gap.
                  if (grp_q == '0) begin
                     if (rem_q == LEN_WIDTH'(1)) begin
                        io_oe_d = 4'b0000;
                        state_d = S_DONE;
                     end else begin
                        rem_d   = rem_q - 1'b1;
                        state_d = S_FETCH;
                     end
                  end else begin
                     grp_d = grp_q - 1'b1;
                     sh_d  = sh_next;
                  end
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         mode_q  <= 2'b00;
         div_q   <= '0;
         cnt_q   <= '0;
         rem_q   <= '0;
         grp_q   <= '0;
         sh_q    <= '0;
         sclk_q  <= 1'b0;
         under_q <= 1'b0;
         io_oe_q <= 4'b0000;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         grp_q   <= grp_d;
         sh_q    <= sh_d;
         sclk_q  <= sclk_d;
         under_q <= under_d;
         io_oe_q <= io_oe_d;
      end
   end

   // Lanes carry the shift register's leading group, masked off whenever enables are low.
   assign io_out    = io_oe_q & lead_group(mode_q, sh_q[DATA_WIDTH-1 -: 4]);
   assign io_oe     = io_oe_q;
   assign sclk      = sclk_q;
   assign busy      = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_SHIFT);
   assign done      = (state_q == S_DONE);
   assign underrun  = under_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_qspi_tx_serializer.sv
// Bench for qspi_tx_serializer: a queue-backed FIFO responder, a lane-group stream
// model, one negedge compare process, and directed plus randomized transfers.
module tb_qspi_tx_serializer;

   localparam int DW = 32;
   localparam int LW = 16;
   localparam int VW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic [LW-1:0] word_count = '0;
   logic [VW-1:0] clk_div = '0;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_data = '0;
   logic          fifo_empty = 1'b1;
   logic          sclk;
   logic [3:0]    io_out;
   logic [3:0]    io_oe;
   logic          busy;
   logic          done;
   logic          underrun;
   logic [2:0]    state_dbg;

   qspi_tx_serializer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .DIV_WIDTH(VW)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .word_count(word_count), .clk_div(clk_div),
      .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
      .sclk(sclk), .io_out(io_out), .io_oe(io_oe),
      .busy(busy), .done(done), .underrun(underrun), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int            n_pass = 0;
   int            n_total = 0;
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] xfer_words[$];
   logic [3:0]    exp_q[$];
   logic [3:0]    rec_q[$];
   logic [3:0]    exp_oe = 4'b0000;
   int            exp_half = 1;
   int            pops = 0;
   int            rises = 0;
   int            dones = 0;
   logic          sclk_prev = 1'b0;
   logic          done_prev = 1'b0;
   logic          low_clean = 1'b0;
   int            phase_len = 0;
   logic [3:0]    mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   function automatic int lanes(input logic [1:0] m);
      return (m == 2'd2) ? 4 : (m == 2'd1) ? 2 : 1;
   endfunction

   function automatic logic [3:0] oe_for(input logic [1:0] m);
      return (m == 2'd2) ? 4'hF : (m == 2'd1) ? 4'h3 : 4'h1;
   endfunction

   // FIFO read port: data appears the cycle after the pop strobe.
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         if (fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
         pops <= pops + 1;
      end
      fifo_empty <= (fifo_q.size() == 0);
   end

   // Compare process: every rising SCLK edge must carry the next expected lane group.
   always @(negedge clk) begin
      if (reset) begin
         sclk_prev = 1'b0;
         done_prev = 1'b0;
         low_clean = 1'b0;
         phase_len = 0;
      end else begin
         if (sclk !== sclk_prev) begin
            if (sclk_prev) chk("high_phase_len", 32'(phase_len), 32'(exp_half));
            else if (low_clean) chk("low_phase_len", 32'(phase_len), 32'(exp_half));
            if (sclk) begin
               rises++;
               rec_q.push_back(io_out);
               if (exp_q.size() == 0) begin
                  chk("unexpected_rise", 32'(exp_q.size()), 32'd1);
               end else begin
                  mon_e = exp_q.pop_front();
                  chk("io_out_at_rise", 32'(io_out), 32'(mon_e));
                  chk("io_oe_at_rise", 32'(io_oe), 32'(exp_oe));
               end
            end else begin
               low_clean = 1'b1;
            end
            phase_len = 1;
         end else begin
            phase_len++;
         end
         sclk_prev = sclk;
         if (fifo_rd_en) begin
            chk("rd_en_while_empty", 32'(fifo_empty), 32'd0);
            low_clean = 1'b0;
         end
         if (done) begin
            chk("done_one_cycle", 32'(done_prev), 32'd0);
            chk("done_io_oe", 32'(io_oe), 32'd0);
            chk("done_io_out", 32'(io_out), 32'd0);
            chk("done_busy", 32'(busy), 32'd0);
            dones++;
         end
         done_prev = done;
      end
   end

   task automatic expect_words(input logic [1:0] m);
      int k;
      logic [DW-1:0] w;
      k = lanes(m);
      foreach (xfer_words[i]) begin
         w = xfer_words[i];
         for (int g = 0; g < DW / k; g++)
            exp_q.push_back(4'((w >> (DW - (g + 1) * k)) & DW'((1 << k) - 1)));
      end
   endtask

   task automatic pulse_start(input logic [1:0] m, input logic [LW-1:0] wc, input logic [VW-1:0] d);
      @(negedge clk);
      mode = m;
      word_count = wc;
      clk_div = d;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mode = 2'($urandom);
      clk_div = VW'($urandom);
      word_count = LW'($urandom);
   endtask

   task automatic wait_done(input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic run_xfer(input logic [1:0] m, input logic [VW-1:0] d, input bit poke);
      int p0, r0, d0;
      bit got;
      p0 = pops; r0 = rises; d0 = dones;
      exp_oe = oe_for(m);
      exp_half = int'(d) + 1;
      rec_q.delete();
      foreach (xfer_words[i]) fifo_q.push_back(xfer_words[i]);
      expect_words(m);
      pulse_start(m, LW'(xfer_words.size()), d);
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("underrun_cleared", 32'(underrun), 32'd0);
      if (poke) begin
         repeat (6) @(negedge clk);
         word_count = LW'(9);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_done(20000, got);
      chk("done_seen", 32'(got), 32'd1);
      @(negedge clk);
      chk("pop_count", 32'(pops - p0), 32'(xfer_words.size()));
      chk("rise_count", 32'(rises - r0), 32'(xfer_words.size() * (DW / lanes(m))));
      chk("done_count", 32'(dones - d0), 32'd1);
      chk("groups_left", 32'(exp_q.size()), 32'd0);
      chk("idle_io_oe", 32'(io_oe), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("underrun_end", 32'(underrun), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0] quad_ref [8];
      int p0, r0, d0;
      bit got;
      quad_ref = '{4'hA, 4'h5, 4'hC, 4'h3, 4'h1, 4'hE, 4'h7, 4'hF};

      repeat (3) @(negedge clk);
      chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("rst_sclk", 32'(sclk), 32'd0);
      chk("rst_io_out", 32'(io_out), 32'd0);
      chk("rst_io_oe", 32'(io_oe), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Quad single word, fastest SCLK
      xfer_words.delete();
      xfer_words.push_back(32'hA5C31E7F);
      run_xfer(2'd2, 8'd0, 1'b0);
      chk("quad_rec_size", 32'(rec_q.size()), 32'd8);
      for (int i = 0; i < 8; i++)
         if (i < rec_q.size()) chk("quad_nibble", 32'(rec_q[i]), 32'(quad_ref[i]));

      // Single lane, two words, 2-cycle phases
      xfer_words.delete();
      xfer_words.push_back(32'h80000001);
      xfer_words.push_back(32'h00000000);
      run_xfer(2'd0, 8'd1, 1'b0);
      chk("single_rec_size", 32'(rec_q.size()), 32'd64);
      for (int i = 0; i < 64; i++)
         if (i < rec_q.size()) chk("single_bit", 32'(rec_q[i]), (i == 0 || i == 31) ? 32'd1 : 32'd0);

      // Dual lane pattern
      xfer_words.delete();
      xfer_words.push_back(32'hE4E4E4E4);
      run_xfer(2'd1, 8'd2, 1'b0);
      chk("dual_rec_size", 32'(rec_q.size()), 32'd16);
      for (int i = 0; i < 16; i++)
         if (i < rec_q.size()) chk("dual_pair", 32'(rec_q[i]), 32'(3 - (i % 4)));

      // Mode 11 behaves as single lane
      xfer_words.delete();
      xfer_words.push_back($urandom);
      run_xfer(2'd3, 8'd0, 1'b0);

      // Underrun: FIFO empty when the fetch begins
      xfer_words.delete();
      xfer_words.push_back(32'h12345678);
      exp_oe = 4'hF;
      exp_half = 1;
      rec_q.delete();
      expect_words(2'd2);
      p0 = pops; d0 = dones;
      pulse_start(2'd2, LW'(1), 8'd0);
      repeat (3) @(negedge clk);
      chk("ur_sclk_low", 32'(sclk), 32'd0);
      chk("ur_busy", 32'(busy), 32'd1);
      chk("ur_flag", 32'(underrun), 32'd1);
      chk("ur_no_pop", 32'(pops - p0), 32'd0);
      fifo_q.push_back(32'h12345678);
      wait_done(2000, got);
      chk("ur_done_seen", 32'(got), 32'd1);
      @(negedge clk);
      chk("ur_flag_sticky", 32'(underrun), 32'd1);
      chk("ur_pop_count", 32'(pops - p0), 32'd1);
      chk("ur_done_count", 32'(dones - d0), 32'd1);
      chk("ur_groups_left", 32'(exp_q.size()), 32'd0);

      // Zero word count: immediate done, no traffic
      p0 = pops; r0 = rises; d0 = dones;
      pulse_start(2'd2, LW'(0), 8'd3);
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("zero_done_drop", 32'(done), 32'd0);
      chk("zero_no_pop", 32'(pops - p0), 32'd0);
      chk("zero_no_rise", 32'(rises - r0), 32'd0);
      chk("zero_done_count", 32'(dones - d0), 32'd1);

      // Start while busy is ignored
      xfer_words.delete();
      xfer_words.push_back($urandom);
      xfer_words.push_back($urandom);
      run_xfer(2'd2, 8'd2, 1'b1);

      // Reset in the middle of a quad word
      xfer_words.delete();
      xfer_words.push_back($urandom);
      xfer_words.push_back($urandom);
      exp_oe = 4'hF;
      exp_half = 2;
      foreach (xfer_words[i]) fifo_q.push_back(xfer_words[i]);
      expect_words(2'd2);
      r0 = rises;
      pulse_start(2'd2, LW'(2), 8'd1);
      for (int i = 0; i < 500; i++) begin
         if (rises - r0 >= 3) break;
         @(negedge clk);
      end
      chk("rst_mid_reached", (rises - r0 >= 3) ? 32'd1 : 32'd0, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("rst_mid_sclk", 32'(sclk), 32'd0);
      chk("rst_mid_io_out", 32'(io_out), 32'd0);
      chk("rst_mid_io_oe", 32'(io_oe), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_done", 32'(done), 32'd0);
      chk("rst_mid_underrun", 32'(underrun), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      p0 = pops;
      repeat (20) @(negedge clk);
      chk("rst_no_pop", 32'(pops - p0), 32'd0);
      chk("rst_idle_sclk", 32'(sclk), 32'd0);
      fifo_q.delete();
      repeat (2) @(negedge clk);
      xfer_words.delete();
      xfer_words.push_back(32'h0F1E2D3C);
      run_xfer(2'd2, 8'd0, 1'b0);

      // Randomized transfers
      for (int t = 0; t < 10; t++) begin
         int n;
         n = $urandom_range(1, 3);
         xfer_words.delete();
         for (int i = 0; i < n; i++) xfer_words.push_back($urandom);
         run_xfer(2'($urandom_range(0, 3)), VW'($urandom_range(0, 3)), 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
